// File: rtl/axis_frame_sequencer_pkg.sv
// Shared types and constants for the frame sequencer slice.
//   in_pixel_t   : 3 x 8-bit pixel carried on the stream
//   seq_state_t  : sequencer FSM encoding (visible to benches)
//   cfg_valid()  : run configuration legality check
package axis_frame_sequencer_pkg;

    localparam int unsigned PIX_W = 24;
    localparam int unsigned MAX_W = 4096;
    localparam int unsigned MAX_H = 4096;
    localparam int unsigned DIM_W = 13;
    localparam int unsigned FRM_W = 16;

    typedef struct packed {
        logic [7:0] ch2;
        logic [7:0] ch1;
        logic [7:0] ch0;
    } in_pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // A run needs a non-empty raster inside the supported size and at least one frame.
    function automatic logic cfg_valid(
        input logic [DIM_W-1:0] w,
        input logic [DIM_W-1:0] h,
        input logic [FRM_W-1:0] f
    );
        return (w != '0) && (w <= DIM_W'(MAX_W)) &&
               (h != '0) && (h <= DIM_W'(MAX_H)) &&
               (f != '0);
    endfunction

endpackage

// File: rtl/axis_frame_sequencer_if.sv
// AXI4-Stream pixel bundle.
//   tdata  : pixel payload
//   tvalid : source has a beat
//   tready : sink takes the beat
//   tuser  : start of frame
//   tlast  : end of line
// master drives payload/valid/user/last; slave is the pixel-input view
// and only uses data/valid/ready.
interface axis_frame_sequencer_if;

    axis_frame_sequencer_pkg::in_pixel_t tdata;
    logic                                tvalid;
    logic                                tready;
    logic                                tuser;
    logic                                tlast;

    modport master (
        output tdata,
        output tvalid,
        output tuser,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );

endinterface

// File: rtl/axis_frame_sequencer_raster.sv
// Raster position tracker for the frame sequencer.
//   clk, rst_n      : clock, synchronous active-low reset
//   clr             : restart position and frame statistics for a new run
//   acc             : one pixel accepted this cycle
//   cfg_w/h/f       : latched raster width, height and frame count
//   sof_c/eol_c     : current position is first pixel of frame / last of line
//   eof_c           : current position is last pixel of frame
//   last_frame_c    : current frame is the final one of the run
//   frames_done     : completed frames since the last clr
module axis_raster_counter
    import axis_frame_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             acc,
    input  logic [DIM_W-1:0] cfg_w,
    input  logic [DIM_W-1:0] cfg_h,
    input  logic [FRM_W-1:0] cfg_f,
    output logic             sof_c,
    output logic             eol_c,
    output logic             eof_c,
    output logic             last_frame_c,
    output logic [FRM_W-1:0] frames_done
);

    logic [DIM_W-1:0] x_q;
    logic [DIM_W-1:0] y_q;
    logic [FRM_W-1:0] frm_q;

    // Position flags describe the pixel that the next accept will carry.
    assign sof_c        = (x_q == '0) && (y_q == '0);
    assign eol_c        = (x_q == cfg_w - DIM_W'(1));
    assign eof_c        = eol_c && (y_q == cfg_h - DIM_W'(1));
    assign last_frame_c = (frm_q == cfg_f - FRM_W'(1));

    // x/y/frame counters advance only on accepted beats.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            x_q         <= '0;
            y_q         <= '0;
            frm_q       <= '0;
            frames_done <= '0;
        end else if (acc) begin
            if (eol_c) begin
                x_q <= '0;
                if (eof_c) begin
                    y_q         <= '0;
                    frm_q       <= frm_q + FRM_W'(1);
                    frames_done <= frames_done + FRM_W'(1);
                end else begin
                    y_q <= y_q + DIM_W'(1);
                end
            end else begin
                x_q <= x_q + DIM_W'(1);
            end
        end
    end

endmodule

// File: rtl/axis_frame_sequencer.sv
// Frame sequencer for the image-processing pixel path: runs cfg_frames
// frames of cfg_width x cfg_height pixels per start, tagging SOF/EOL,
// through a single registered output stage.
//   aclk, aresetn          : clock, synchronous active-low reset
//   cfg_width/height/frames: run configuration, sampled on a valid start
//   start                  : single-cycle run request (honoured in IDLE only)
//   busy                   : run in progress (RUN or FLUSH)
//   done                   : one-cycle pulse when the run has fully drained
//   err_cfg                : one-cycle pulse when a start is rejected
//   frames_done            : frames fully accepted in the current/last run
//   s_axis                 : pixel input stream
//   m_axis                 : pixel output stream with tuser=SOF, tlast=EOL
module axis_frame_sequencer
    import axis_frame_sequencer_pkg::*;
(
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [DIM_W-1:0]              cfg_width,
    input  logic [DIM_W-1:0]              cfg_height,
    input  logic [FRM_W-1:0]              cfg_frames,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          err_cfg,
    output logic [FRM_W-1:0]              frames_done,
    axis_frame_sequencer_if.slave         s_axis,
    axis_frame_sequencer_if.master        m_axis
);

    seq_state_t       state_q;
    seq_state_t       state_nxt;
    logic             cfg_load_c;
    logic             err_nxt;

    logic [DIM_W-1:0] cfg_w_q;
    logic [DIM_W-1:0] cfg_h_q;
    logic [FRM_W-1:0] cfg_f_q;

    in_pixel_t        m_tdata_q;
    logic             m_tvalid_q;
    logic             m_tuser_q;
    logic             m_tlast_q;

    logic             s_tready_c;
    logic             acc_c;
    logic             sof_c;
    logic             eol_c;
    logic             eof_c;
    logic             last_frame_c;

    // Take a pixel only while running and the output stage can hold it.
    assign s_tready_c   = (state_q == RUN) && (!m_tvalid_q || m_axis.tready);
    assign acc_c        = s_axis.tvalid && s_tready_c;
    assign s_axis.tready = s_tready_c;

    assign m_axis.tdata  = m_tdata_q;
    assign m_axis.tvalid = m_tvalid_q;
    assign m_axis.tuser  = m_tuser_q;
    assign m_axis.tlast  = m_tlast_q;

    axis_raster_counter u_raster (
        .clk          (aclk),
        .rst_n        (aresetn),
        .clr          (cfg_load_c),
        .acc          (acc_c),
        .cfg_w        (cfg_w_q),
        .cfg_h        (cfg_h_q),
        .cfg_f        (cfg_f_q),
        .sof_c        (sof_c),
        .eol_c        (eol_c),
        .eof_c        (eof_c),
        .last_frame_c (last_frame_c),
        .frames_done  (frames_done)
    );

    // State register plus status outputs registered from the next state.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err_cfg <= 1'b0;
        end else begin
            state_q <= state_nxt;
            busy    <= (state_nxt == RUN) || (state_nxt == FLUSH);
            done    <= (state_nxt == DONE);
            err_cfg <= err_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt  = state_q;
        cfg_load_c = 1'b0;
        err_nxt    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_valid(cfg_width, cfg_height, cfg_frames)) begin
                        state_nxt  = RUN;
                        cfg_load_c = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (acc_c && eof_c && last_frame_c) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                // Wait for the final beat to leave the output stage.
                if (!m_tvalid_q || m_axis.tready) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Run configuration is frozen at the accepted start.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cfg_w_q <= '0;
            cfg_h_q <= '0;
            cfg_f_q <= '0;
        end else if (cfg_load_c) begin
            cfg_w_q <= cfg_width;
            cfg_h_q <= cfg_height;
            cfg_f_q <= cfg_frames;
        end
    end

    // Output stage: a new accept overwrites a draining beat without a bubble;
    // contents hold while stalled.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tuser_q  <= 1'b0;
            m_tlast_q  <= 1'b0;
        end else if (acc_c) begin
            m_tdata_q  <= s_axis.tdata;
            m_tvalid_q <= 1'b1;
            m_tuser_q  <= sof_c;
            m_tlast_q  <= eol_c;
        end else if (m_axis.tready) begin
            m_tvalid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_frame_sequencer.sv
// Scoreboard bench for axis_frame_sequencer: accepted input beats are
// pushed with their expected SOF/EOL tags from a raster model, and popped
// when the output stream transfers.
module tb_axis_frame_sequencer;
    import axis_frame_sequencer_pkg::*;

    logic             clk;
    logic             aresetn;
    logic [DIM_W-1:0] cfg_width;
    logic [DIM_W-1:0] cfg_height;
    logic [FRM_W-1:0] cfg_frames;
    logic             start;
    logic             busy;
    logic             done;
    logic             err_cfg;
    logic [FRM_W-1:0] frames_done;

    axis_frame_sequencer_if s_if ();
    axis_frame_sequencer_if m_if ();

    axis_frame_sequencer dut (
        .aclk        (clk),
        .aresetn     (aresetn),
        .cfg_width   (cfg_width),
        .cfg_height  (cfg_height),
        .cfg_frames  (cfg_frames),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .err_cfg     (err_cfg),
        .frames_done (frames_done),
        .s_axis      (s_if),
        .m_axis      (m_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total_cnt = 0;
    int          bad_cnt   = 0;
    logic [25:0] sb[$];
    logic [23:0] pix = 24'h100000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One full run: start, stream pixels, score output, wait for done.
    // rmode: 0 = sink always ready, 1 = ready on even cycles, 2 = random sink + source gaps.
    // mid: re-issue start with a new width while running.
    task automatic run_job(input int w, input int h, input int f, input int rmode, input bit mid);
        int          total;
        int          sent;
        int          beats;
        int          mx;
        int          my;
        bit          seen_done;
        logic [25:0] exp;
        total     = w * h * f;
        sent      = 0;
        beats     = 0;
        mx        = 0;
        my        = 0;
        seen_done = 1'b0;
        @(posedge clk); #1;
        cfg_width  = DIM_W'(w);
        cfg_height = DIM_W'(h);
        cfg_frames = FRM_W'(f);
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_on", 32'(busy), 32'd1);
        check("fd_clear", 32'(frames_done), 32'd0);
        for (int cyc = 0; cyc < 2000 && !seen_done; cyc++) begin
            if (rmode == 0)      m_if.tready = 1'b1;
            else if (rmode == 1) m_if.tready = (cyc % 2 == 0);
            else                 m_if.tready = 1'($urandom_range(0, 1));
            s_if.tvalid = (sent < total) && (rmode != 2 || $urandom_range(0, 3) != 0);
            s_if.tdata  = pix;
            if (mid && cyc == 2) begin
                start     = 1'b1;
                cfg_width = DIM_W'(8);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (m_if.tvalid && m_if.tready) begin
                if (sb.size() == 0) begin
                    check("spurious_beat", 32'(m_if.tvalid), 32'd0);
                end else begin
                    exp = sb.pop_front();
                    check("beat", {6'd0, m_if.tuser, m_if.tlast, m_if.tdata}, {6'd0, exp});
                    beats++;
                end
            end else if (m_if.tvalid) begin
                if (sb.size() != 0)
                    check("stall_hold", {6'd0, m_if.tuser, m_if.tlast, m_if.tdata}, {6'd0, sb[0]});
                else
                    check("stall_empty", 32'(m_if.tvalid), 32'd0);
            end
            if (s_if.tvalid && s_if.tready) begin
                sb.push_back({(mx == 0 && my == 0), (mx == w - 1), pix});
                pix++;
                sent++;
                if (mx == w - 1) begin
                    mx = 0;
                    my = (my == h - 1) ? 0 : my + 1;
                end else begin
                    mx++;
                end
            end
            if (done) begin
                seen_done = 1'b1;
                check("done_fd", 32'(frames_done), 32'(f));
                check("done_busy", 32'(busy), 32'd0);
                check("done_mvalid", 32'(m_if.tvalid), 32'd0);
                check("done_sready", 32'(s_if.tready), 32'd0);
                check("beats", 32'(beats), 32'(total));
            end
            @(posedge clk); #1;
        end
        check("timeout", 32'(seen_done), 32'd1);
        check("done_pulse", 32'(done), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        start       = 1'b0;
    endtask

    // Rejected start: err_cfg pulses once, nothing starts.
    task automatic bad_start(input int w, input int h, input int f);
        @(posedge clk); #1;
        cfg_width   = DIM_W'(w);
        cfg_height  = DIM_W'(h);
        cfg_frames  = FRM_W'(f);
        s_if.tvalid = 1'b1;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("err_pulse", 32'(err_cfg), 32'd1);
        check("err_busy", 32'(busy), 32'd0);
        check("err_sready", 32'(s_if.tready), 32'd0);
        @(negedge clk);
        check("err_clear", 32'(err_cfg), 32'd0);
        check("err_idle_sready", 32'(s_if.tready), 32'd0);
        s_if.tvalid = 1'b0;
    endtask

    initial begin
        aresetn     = 1'b0;
        start       = 1'b0;
        cfg_width   = '0;
        cfg_height  = '0;
        cfg_frames  = '0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err_cfg), 32'd0);
        check("rst_fd", 32'(frames_done), 32'd0);
        check("rst_mvalid", 32'(m_if.tvalid), 32'd0);
        check("rst_tuser", 32'(m_if.tuser), 32'd0);
        check("rst_tlast", 32'(m_if.tlast), 32'd0);
        check("rst_tdata", 32'(m_if.tdata), 32'd0);
        check("rst_sready", 32'(s_if.tready), 32'd0);
        @(posedge clk); #1;
        aresetn = 1'b1;

        run_job(4, 2, 1, 0, 1'b0);
        run_job(3, 3, 2, 1, 1'b0);
        bad_start(0, 4, 1);
        bad_start(4, 4097, 1);
        bad_start(4, 4, 0);
        run_job(1, 1, 3, 0, 1'b0);
        run_job(4, 2, 1, 0, 1'b1);
        run_job(8, 1, 1, 0, 1'b0);
        run_job(5, 2, 2, 2, 1'b0);

        // Reset in the middle of a frame after five accepted beats.
        @(posedge clk); #1;
        cfg_width  = DIM_W'(4);
        cfg_height = DIM_W'(4);
        cfg_frames = FRM_W'(1);
        start      = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
        m_if.tready = 1'b1;
        s_if.tvalid = 1'b1;
        repeat (5) begin
            s_if.tdata = pix;
            pix++;
            @(posedge clk); #1;
        end
        aresetn     = 1'b0;
        s_if.tvalid = 1'b0;
        @(posedge clk); #1;
        aresetn = 1'b1;
        @(negedge clk);
        check("mid_rst_mvalid", 32'(m_if.tvalid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_fd", 32'(frames_done), 32'd0);
        check("mid_rst_sready", 32'(s_if.tready), 32'd0);
        sb.delete();
        run_job(4, 4, 1, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/axis_frame_sequencer.md
Name: axis_frame_sequencer

Overview:
- Frame-level controller that sequences an AXI4-Stream pixel path feeding the image-processing datapath.
- Counts x/y over a run-time-configured W×H raster and generates tuser (SOF) and tlast (EOL).
- Runs a programmed number of frames per start command, then reports done.
- Sits between the pixel source (DMA/pattern generator) and the processing core; one registered output stage.

Parameters:
- PIX_W, 24, pixel data width (in_pixel_t: 3 channels × 8 bit).
- MAX_W, 4096, maximum legal frame width.
- MAX_H, 4096, maximum legal frame height.
- DIM_W, 13, width of dimension ports/counters (must hold MAX_W and MAX_H).
- FRM_W, 16, width of frame-count ports.

Ports:
- aclk in 1 clock
- aresetn in 1 synchronous active-low reset
- cfg_width in DIM_W pixels per line
- cfg_height in DIM_W lines per frame
- cfg_frames in FRM_W frames per run
- start in 1 single-cycle run request
- busy out 1 run in progress
- done out 1 one-cycle pulse at run completion
- err_cfg out 1 one-cycle pulse on rejected start
- frames_done out FRM_W frames fully accepted in the current/last run
- s_axis_tdata in PIX_W input pixel
- s_axis_tvalid in 1
- s_axis_tready out 1
- m_axis_tdata out PIX_W output pixel
- m_axis_tvalid out 1
- m_axis_tready in 1
- m_axis_tuser out 1 first pixel of frame (x=0, y=0)
- m_axis_tlast out 1 last pixel of line (x=W-1)

Behaviour:
- All state is updated on the rising edge of aclk. When aresetn=0 at an edge, everything clears: state=IDLE, busy=0, done=0, err_cfg=0, frames_done=0, m_axis_tvalid=0, tuser=0, tlast=0, tdata=0, s_axis_tready=0.
- Reset mid-frame discards the in-flight beat; no partial-frame recovery is attempted.
- States:
  - IDLE → RUN on start with a valid configuration.
  - RUN → FLUSH when the last pixel of the last frame is accepted.
  - FLUSH → DONE when the output register is empty, or is drained that cycle (m_tvalid && m_tready).
  - DONE → IDLE unconditionally after one cycle.
- Valid configuration: 1 ≤ cfg_width ≤ MAX_W, 1 ≤ cfg_height ≤ MAX_H, cfg_frames ≥ 1.
  - Valid start in IDLE: latch all cfg_* into internal registers, clear x, y, frame index and frames_done.
  - Invalid start: pulse err_cfg for one cycle and stay in IDLE.
  - start outside IDLE is ignored; cfg_* changes during a run have no effect.
- busy = 1 in RUN and FLUSH; 0 in IDLE and DONE. done = 1 only in DONE.
- Handshake:
  - s_axis_tready = (state==RUN) && (!m_axis_tvalid || m_axis_tready). It is combinational from registered state plus m_axis_tready.
  - Accept = s_axis_tvalid && s_axis_tready. On accept, load tdata, tuser=(x==0 && y==0) and tlast=(x==W-1) into the output register and set m_axis_tvalid=1.
  - When m_axis_tready=1 and there is no accept, clear m_axis_tvalid.
  - Output register contents stay stable while m_axis_tvalid && !m_axis_tready (AXI rule).
  - Latency: 1 cycle input→output; full throughput of 1 pixel/cycle when m_axis_tready stays high.
- Counters advance on accept only:
  - x wraps at W-1 → 0 and increments y.
  - y wraps at H-1 → 0, increments the frame index and frames_done.
  - When frame index == cfg_frames-1 at wrap, go to FLUSH; s_axis_tready is 0 from the next cycle on.
  - Counter arithmetic is unsigned DIM_W / FRM_W bits; W=1 gives tlast on every beat; W=H=1 gives tuser and tlast on the same beat.
- Simultaneous events: an output drain and a new accept in the same cycle replace the register contents with no bubble.

Decomposition:
- imageProcessPkg holds in_pixel_t (PIX_W) and the MAX_W/MAX_H defaults.
- A seq_state_t enum (IDLE/RUN/FLUSH/DONE) also goes in the package, for testbench visibility.
- Natural sub-module: axis_raster_counter. It holds x/y/frame counters with accept, wrap and last flags (sof, eol, eof, last_frame) and is instantiated once; the sequencer keeps the FSM and output register.

Test Plan:
- W=4, H=2, frames=1, tvalid and tready always 1 → 8 beats, tuser on beat 0 only, tlast on beats 3 and 7, done 1 cycle after FLUSH, frames_done=1.
- W=3, H=3, frames=2, m_axis_tready toggling 1010… → 18 beats, output data identical to input order, data stable during stalls, tuser on beats 0 and 9, frames_done=2.
- cfg_width=0, then cfg_height=4097, then cfg_frames=0 with start → err_cfg pulse each time, busy stays 0, s_axis_tready stays 0.
- W=H=1, frames=3 → 3 beats each with tuser=1 and tlast=1, then done.
- Mid-run start plus cfg change (W=4 → W=8) → ignored, still 4-pixel lines; after done, new start with W=8 uses 8.
- aresetn=0 asserted at beat 5 of W=4, H=4 → next cycle m_axis_tvalid=0, busy=0, frames_done=0; new start resumes at x=0, y=0 with tuser.
